instruction_fetch_unit: RTL and testbench

- Producer side of the instruction interface consumed by the Controller/ALUControl decode path.
- Holds the program counter and a word-addressed instruction memory.
- Applies branch redirects (PCSrc/BranchTarget from the Branch block) and jumps.
- Delivers Instruction/PCPlus4 through a registered IF/ID stage with stall, flush and valid qualification.

---
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus: control/load signals from the pipeline controller and
// loader towards the fetch unit, plus the IF/ID outputs towards decode.
interface instruction_fetch_unit_if #(
    parameter int IMEM_DEPTH = 128
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    logic              PCSrc;
    logic [31:0]       BranchTarget;
    logic              Jump;
    logic [31:0]       JumpTarget;
    logic              Stall;
    logic              Flush;
    logic              LoadEn;
    logic [ADDR_W-1:0] LoadAddr;
    logic [31:0]       LoadData;

    logic [31:0]       PC;
    logic [31:0]       Instruction;
    logic [31:0]       PCPlus4;
    logic              Valid;
    logic              AddrFault;

    // Controller/loader side: drives redirects, hazards and program load.
    modport master (
        output PCSrc, BranchTarget, Jump, JumpTarget, Stall, Flush,
               LoadEn, LoadAddr, LoadData,
        input  PC, Instruction, PCPlus4, Valid, AddrFault
    );

    // Fetch unit side.
    modport slave (
        input  PCSrc, BranchTarget, Jump, JumpTarget, Stall, Flush,
               LoadEn, LoadAddr, LoadData,
        output PC, Instruction, PCPlus4, Valid, AddrFault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program counter, word-addressed instruction memory
// with a program-load port, and a registered IF/ID stage with stall, flush
// and valid qualification. Branch redirects take priority over jumps, and
// any redirect overrides a stall.
module instruction_fetch_unit #(
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic                    Clk,
    input logic                    Rst,
    instruction_fetch_unit_if.slave bus
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    logic [31:0]       imem [IMEM_DEPTH];

    logic [31:0]       pc_q;
    logic [31:0]       instr_q;
    logic [31:0]       pc_plus4_q;
    logic              valid_q;
    logic              fault_q;

    logic              redirect;
    logic [31:0]       target;
    logic              target_misaligned;
    logic [31:0]       pc_plus4;
    logic [31:0]       next_pc;
    logic [ADDR_W-1:0] fetch_index;
    logic              fetch_in_range;
    logic [31:0]       fetch_word;

    // Next-PC selection and fetch address decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        redirect          = bus.PCSrc || bus.Jump;
        target            = bus.PCSrc ? bus.BranchTarget : bus.JumpTarget;
        target_misaligned = redirect && (target[1:0] != 2'b00);
        pc_plus4          = pc_q + 32'd4;
        next_pc           = pc_plus4;
        if (redirect) begin
            next_pc = {target[31:2], 2'b00};
        end else if (bus.Stall) begin
            next_pc = pc_q;
        end
        fetch_index    = pc_q[ADDR_W+1:2];
        fetch_in_range = (pc_q[31:ADDR_W+2] == '0);
        fetch_word     = fetch_in_range ? imem[fetch_index] : 32'h0000_0000;
    end

    // Program-load write port; a same-edge fetch of this index sees the old word.
    // NOTE: memory arrays are deliberately left out of reset so they map onto RAM and a loaded program survives Rst.
    always_ff @(posedge Clk) begin
        if (bus.LoadEn) begin
            imem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    // PC, IF/ID stage and sticky fault flag.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pc_q <= next_pc;
            if (bus.Flush || redirect) begin
                instr_q    <= 32'h0000_0000;
                pc_plus4_q <= 32'h0000_0000;
                valid_q    <= 1'b0;
            end else if (!bus.Stall) begin
                instr_q    <= fetch_word;
                pc_plus4_q <= pc_plus4;
                valid_q    <= 1'b1;
            end
            if (target_misaligned || !fetch_in_range) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.PC          = pc_q;
    assign bus.Instruction = instr_q;
    assign bus.PCPlus4     = pc_plus4_q;
    assign bus.Valid       = valid_q;
    assign bus.AddrFault   = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;
    localparam int DEPTH = 128;

    logic Clk;
    logic Rst;
    int   errors;
    int   checks;

    instruction_fetch_unit_if #(.IMEM_DEPTH(DEPTH)) bus ();

    instruction_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Compare the full observable state against expected values.
    task automatic expect_state(input string name, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] pp4, input logic vld, input logic flt);
        checks++;
        if (bus.PC !== pc) begin errors++; $display("FAIL %s pc: got %h want %h", name, bus.PC, pc); end
        checks++;
        if (bus.Instruction !== ins) begin errors++; $display("FAIL %s instr: got %h want %h", name, bus.Instruction, ins); end
        checks++;
        if (bus.PCPlus4 !== pp4) begin errors++; $display("FAIL %s pcplus4: got %h want %h", name, bus.PCPlus4, pp4); end
        checks++;
        if (bus.Valid !== vld) begin errors++; $display("FAIL %s valid: got %b want %b", name, bus.Valid, vld); end
        checks++;
        if (bus.AddrFault !== flt) begin errors++; $display("FAIL %s fault: got %b want %b", name, bus.AddrFault, flt); end
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic test_reset;
        bus.PCSrc = 0; bus.BranchTarget = 0; bus.Jump = 0; bus.JumpTarget = 0;
        bus.Stall = 0; bus.Flush = 0; bus.LoadEn = 0; bus.LoadAddr = 0; bus.LoadData = 0;
        Rst = 1'b0;
        #2;
        expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Program load while held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            bus.LoadEn   = 1'b1;
            bus.LoadAddr = 7'(i);
            bus.LoadData = (i == 0) ? 32'h2008_0005 : (i == 1) ? 32'h2009_0003 :
                           (i == 2) ? 32'h0109_5020 : fill_word(i);
            tick();
        end
        bus.LoadEn = 1'b0;
        expect_state("reset_after_load", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_sequential_fetch;
        Rst = 1'b1;
        tick(); expect_state("seq0", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
        tick(); expect_state("seq1", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 1'b0);
        tick(); expect_state("seq2", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 1'b0);
    endtask

    task automatic test_branch;
        bus.PCSrc = 1'b1; bus.BranchTarget = 32'h40;
        tick(); expect_state("branch_bubble", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.PCSrc = 1'b0;
        tick(); expect_state("branch_target", 32'h44, fill_word(16), 32'h44, 1'b1, 1'b0);
    endtask

    task automatic test_stall_jump;
        tick(); expect_state("pre_stall", 32'h48, fill_word(17), 32'h48, 1'b1, 1'b0);
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_state("stall_hold", 32'h48, fill_word(17), 32'h48, 1'b1, 1'b0);
        end
        bus.Stall = 1'b0;
        tick(); expect_state("stall_release", 32'h4C, fill_word(18), 32'h4C, 1'b1, 1'b0);
        bus.Stall = 1'b1; bus.Jump = 1'b1; bus.JumpTarget = 32'h8;
        tick(); expect_state("jump_over_stall", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.Stall = 1'b0; bus.Jump = 1'b0;
        tick(); expect_state("jump_target", 32'hC, 32'h0109_5020, 32'hC, 1'b1, 1'b0);
    endtask

    task automatic test_flush;
        bus.Flush = 1'b1;
        tick(); expect_state("flush", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.Flush = 1'b0;
        tick(); expect_state("after_flush", 32'h14, fill_word(4), 32'h14, 1'b1, 1'b0);
    endtask

    task automatic test_load_collision;
        bus.LoadEn = 1'b1; bus.LoadAddr = 7'd5; bus.LoadData = 32'hDEAD_BEEF;
        tick(); expect_state("load_same_edge_old", 32'h18, fill_word(5), 32'h18, 1'b1, 1'b0);
        bus.LoadEn = 1'b0;
        bus.Jump = 1'b1; bus.JumpTarget = 32'h14;
        tick(); expect_state("reload_jump", 32'h14, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.Jump = 1'b0;
        tick(); expect_state("load_new_word", 32'h18, 32'hDEAD_BEEF, 32'h18, 1'b1, 1'b0);
    endtask

    task automatic test_fault;
        bus.PCSrc = 1'b1; bus.BranchTarget = 32'h42;
        tick(); expect_state("misaligned_branch", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.PCSrc = 1'b0; bus.Jump = 1'b1; bus.JumpTarget = 32'(4 * DEPTH);
        tick(); expect_state("jump_out_of_range", 32'h200, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.Jump = 1'b0;
        tick(); expect_state("fetch_out_of_range", 32'h204, 32'h0, 32'h204, 1'b1, 1'b1);
        bus.Jump = 1'b1; bus.JumpTarget = 32'h0;
        tick(); expect_state("fault_sticky", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.Jump = 1'b0;
    endtask

    task automatic test_async_reset;
        bus.Stall = 1'b1;
        tick();
        #2;
        Rst = 1'b0;
        #1;
        expect_state("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.Stall = 1'b0;
        tick();
        Rst = 1'b1;
        tick(); expect_state("restart0", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
        tick(); expect_state("restart1", 32'h8, 32'h2009_0003, 32'h8, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        bus.Jump = 1'b1; bus.JumpTarget = 32'hFFFF_FFFC;
        tick(); expect_state("jump_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.Jump = 1'b0;
        tick(); expect_state("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick(); expect_state("after_wrap", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sequential_fetch();
        test_branch();
        test_stall_jump();
        test_flush();
        test_load_collision();
        test_fault();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
